bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter DW, default 16, the unsigned binary input width.
REQ-002 SHALL have parameter DIGITS, default 5, the number of BCD output digits; DIGITS*4 >= ceil(DW*log10(2))*4 is a legal-configuration rule.
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port i_start  input  1  conversion request; sampled only when o_busy=0.
REQ-006 SHALL have port i_bin  input  DW  unsigned operand; captured on the edge that accepts i_start.
REQ-007 SHALL have port o_bcd  output  4*DIGITS  result; digit k at bits [4k+3:4k], digit 0 = units.
REQ-008 SHALL have port o_busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port o_done  output  1  one-cycle pulse marking o_bcd updated with a new result.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 SHALL, in IDLE or DONE with i_start=1, load the shift register with i_bin, clear all working BCD digits, clear the shift counter, and go to SHIFT.
REQ-012 SHALL, in DONE with i_start=0, go to IDLE; in IDLE with i_start=0, stay in IDLE.
REQ-013 SHALL, in SHIFT, perform one double-dabble iteration per cycle: each working digit > 4 gets +3 (4-bit result, digit <= 9 before add), then shift the {BCD, binary} register left by 1.
REQ-014 SHALL apply the add-3 correction to all digits in parallel before the shift, within the same cycle.
REQ-015 SHALL perform exactly DW iterations, counted by a counter of width clog2(DW+1), then go to DONE.
REQ-016 SHALL copy the working BCD register to o_bcd on the edge that enters DONE; o_bcd SHALL otherwise hold its value.
REQ-017 SHALL assert o_done only while in DONE, for exactly one cycle per conversion.
REQ-018 SHALL assert o_busy exactly while in SHIFT.
REQ-019 SHALL have a latency of DW edges after the accepting edge: o_done is high in the cycle following the DW-th SHIFT edge.
REQ-020 SHALL ignore i_start and i_bin while o_busy=1; no queuing, no abort.
REQ-021 SHALL support back-to-back conversions: i_start=1 during DONE starts the next conversion with no IDLE cycle; o_done still pulses for one cycle only.
REQ-022 SHALL treat i_bin as unsigned; i_bin = 2^DW-1 SHALL convert without digit overflow when REQ-002 holds.

Reset
REQ-023 SHALL, on i_rst=1 at a rising edge, enter IDLE and set o_bcd=0, o_done=0, o_busy=0, working registers and counter to 0.
REQ-024 SHALL let reset override every state, including mid-SHIFT; the aborted conversion produces no o_done and o_bcd reads 0.
REQ-025 SHALL give i_rst priority over i_start in the same cycle.

Verification
REQ-026 SHALL cover i_bin=0, start -> after 16 edges o_done=1 for 1 cycle, o_bcd=0x00000, o_busy high for 16 cycles.
REQ-027 SHALL cover i_bin=65535 -> o_bcd=0x65535; i_bin=255 -> o_bcd=0x00255; i_bin=9 -> 0x00009; i_bin=10 -> 0x00010.
REQ-028 SHALL cover start with i_bin=1234, then i_start=1 with i_bin=999 at busy cycle 5 -> o_bcd=0x01234, a single o_done pulse.
REQ-029 SHALL cover i_rst=1 at SHIFT cycle 8 of i_bin=4660 -> next cycle IDLE, o_busy=0, o_bcd=0, no o_done.
REQ-030 SHALL cover back-to-back: 42 then 58 (start held in DONE) -> o_done pulses 17 cycles apart, o_bcd 0x00042 then 0x00058.
REQ-031 SHALL include a randomized check of all DW=16 values against a reference model (integer-to-decimal-digits).

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using double-dabble (shift-and-add-3).
// Each SHIFT cycle handles one binary bit; the result is published to o_bcd when DONE is entered.
module bin2bcd_seq #(
   parameter int DW     = 16,
   parameter int DIGITS = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [DW-1:0]         i_bin,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int CW = $clog2(DW + 1);
   localparam int BW = 4 * DIGITS;
   localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     bin_q, bin_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic [BW-1:0]     out_q, out_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     bcd_adj;
   logic [BW+DW-1:0]  shifted;

   // Add-3 correction on every digit in parallel, ahead of the shift in the same cycle.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] > 4'd4) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                               : bcd_q[4*gi +: 4];
      end
   endgenerate

   assign shifted = {bcd_adj, bin_q} << 1;

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               bin_d   = i_bin;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            bcd_d = shifted[BW+DW-1:DW];
            bin_d = shifted[DW-1:0];
            cnt_d = cnt_q + CW'(1);
            // Last iteration: publish the post-shift digits on the edge entering DONE.
            if (cnt_q == LAST_CNT) begin
               out_d   = shifted[BW+DW-1:DW];
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_bcd  = out_q;
   assign o_busy = (state_q == S_SHIFT);
   assign o_done = (state_q == S_DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector and random bench for bin2bcd_seq (DW=16, DIGITS=5).
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] bin;
   logic [19:0] bcd;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   bin2bcd_seq #(.DW(16), .DIGITS(5)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_bin   (bin),
      .o_bcd   (bcd),
      .o_busy  (busy),
      .o_done  (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] bin;
      logic [19:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] ref_bcd(input int v);
      logic [19:0] r;
      int x;
      x = v;
      r = '0;
      for (int k = 0; k < 5; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Runs one conversion from a negedge; i=0 is the first cycle after the accepting edge.
   task automatic do_conv(input logic [15:0] b, output logic [19:0] res,
                          output int busy_n, output int done_n, output int done_at);
      start = 1'b1;
      bin   = b;
      @(negedge clk);
      start = 1'b0;
      busy_n  = 0;
      done_n  = 0;
      done_at = -1;
      res     = 'x;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            res = bcd;
            if (done_at < 0) done_at = i;
         end
         @(negedge clk);
      end
   endtask

   vec_t        vecs[12];
   logic [19:0] res;
   int          busy_n, done_n, done_at, t1, t2;
   logic [15:0] rv;

   initial begin
      vecs[0]  = '{16'd0,     20'h00000};
      vecs[1]  = '{16'd65535, 20'h65535};
      vecs[2]  = '{16'd255,   20'h00255};
      vecs[3]  = '{16'd9,     20'h00009};
      vecs[4]  = '{16'd10,    20'h00010};
      vecs[5]  = '{16'd1,     20'h00001};
      vecs[6]  = '{16'd99,    20'h00099};
      vecs[7]  = '{16'd100,   20'h00100};
      vecs[8]  = '{16'd4095,  20'h04095};
      vecs[9]  = '{16'd50000, 20'h50000};
      vecs[10] = '{16'd32768, 20'h32768};
      vecs[11] = '{16'd9999,  20'h09999};

      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(negedge clk);
      chk("reset_bcd",  32'(bcd),  32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table
      foreach (vecs[n]) begin
         do_conv(vecs[n].bin, res, busy_n, done_n, done_at);
         $display("conv bin=%0d bcd=%h busy=%0d done_n=%0d done_at=%0d",
                  vecs[n].bin, res, busy_n, done_n, done_at);
         chk($sformatf("vec%0d_bcd", n),     32'(res),     32'(vecs[n].exp));
         chk($sformatf("vec%0d_busy", n),    32'(busy_n),  32'd16);
         chk($sformatf("vec%0d_done_n", n),  32'(done_n),  32'd1);
         chk($sformatf("vec%0d_done_at", n), 32'(done_at), 32'd16);
         chk($sformatf("vec%0d_hold", n),    32'(bcd),     32'(vecs[n].exp));
      end

      // Start while busy is ignored
      start = 1'b1;
      bin   = 16'd1234;
      @(negedge clk);
      start   = 1'b0;
      done_n  = 0;
      res     = 'x;
      for (int i = 0; i < 40; i++) begin
         if (i == 4) begin
            start = 1'b1;
            bin   = 16'd999;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            done_n++;
            res = bcd;
         end
         @(negedge clk);
      end
      $display("conv busy_restart bcd=%h done_n=%0d", res, done_n);
      chk("busy_ignore_bcd",    32'(res),    32'h01234);
      chk("busy_ignore_done_n", 32'(done_n), 32'd1);

      // Reset mid-SHIFT
      start = 1'b1;
      bin   = 16'd4660;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("midrst_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_bcd",  32'(bcd),  32'h0);
      chk("midrst_done", 32'(done), 32'd0);
      done_n = 0;
      for (int i = 0; i < 30; i++) begin
         if (done || busy) done_n++;
         @(negedge clk);
      end
      $display("conv midreset activity=%0d bcd=%h", done_n, bcd);
      chk("midrst_no_done", 32'(done_n), 32'd0);

      // Reset wins over start in the same cycle
      rst   = 1'b1;
      start = 1'b1;
      bin   = 16'd77;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      $display("conv rst_vs_start busy=%0d", busy);
      chk("rst_prio_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("rst_prio_busy2", 32'(busy), 32'd0);

      // Back-to-back: 42 then 58 with start held in DONE
      start = 1'b1;
      bin   = 16'd42;
      @(negedge clk);
      start = 1'b0;
      t1 = -1;
      t2 = -1;
      done_n = 0;
      for (int i = 0; i < 60; i++) begin
         start = 1'b0;
         if (done) begin
            done_n++;
            if (t1 < 0) begin
               t1 = i;
               chk("b2b_first_bcd", 32'(bcd), 32'h00042);
               start = 1'b1;
               bin   = 16'd58;
            end else if (t2 < 0) begin
               t2 = i;
               chk("b2b_second_bcd", 32'(bcd), 32'h00058);
            end
         end
         @(negedge clk);
      end
      start = 1'b0;
      $display("conv back_to_back t1=%0d t2=%0d done_n=%0d", t1, t2, done_n);
      chk("b2b_gap",    32'(t2 - t1), 32'd17);
      chk("b2b_done_n", 32'(done_n),  32'd2);

      // Random values against the decimal-digit model
      for (int r = 0; r < 300; r++) begin
         rv = 16'($urandom_range(0, 65535));
         do_conv(rv, res, busy_n, done_n, done_at);
         $display("conv rand bin=%0d bcd=%h", rv, res);
         chk($sformatf("rand_bcd_%0d", rv),    32'(res),    32'(ref_bcd(int'(rv))));
         chk($sformatf("rand_done_n_%0d", rv), 32'(done_n), 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
